// File: rtl/result_writer_pkg.sv
// Shared types and constants for the quantised-result write stage.
// Optional completion tracking is enabled with RESULT_WRITER_DONE_TRACK_EN.
package result_writer_pkg;
    localparam int RW_ARRAY_SIZE        = 8;
    localparam int RW_OUTPUT_DATA_WIDTH = 16;
    localparam int RW_NUM_BANKS         = 3;
    localparam int RW_ADDR_WIDTH        = 6;
    localparam int RW_ROWS_PER_SET      = 8;
    localparam int RW_FIFO_DEPTH        = 4;

    localparam int BANK_W = $clog2(RW_NUM_BANKS);
    localparam int DROP_W = 8;

    typedef struct packed {
        logic [BANK_W-1:0]                                bank;
        logic [RW_ADDR_WIDTH-1:0]                         row;
        logic [RW_ARRAY_SIZE*RW_OUTPUT_DATA_WIDTH-1:0]    data;
    } rw_entry_t;

    // Bank index width for an arbitrary bank count (never zero bits).
    function automatic int bank_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/result_writer_if.sv
// Row-vector input stream from the quantiser into result_writer.
interface result_writer_if
    import result_writer_pkg::*;
#(
    parameter int ARRAY_SIZE        = RW_ARRAY_SIZE,
    parameter int OUTPUT_DATA_WIDTH = RW_OUTPUT_DATA_WIDTH,
    parameter int NUM_BANKS         = RW_NUM_BANKS,
    parameter int ADDR_WIDTH        = RW_ADDR_WIDTH
) ();
    localparam int BW = bank_w(NUM_BANKS);

    logic                                in_valid;
    logic                                in_ready;
    logic [BW-1:0]                       in_bank;
    logic [ADDR_WIDTH-1:0]               in_row;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data;

    modport master (output in_valid, in_bank, in_row, in_data, input  in_ready);
    modport slave  (input  in_valid, in_bank, in_row, in_data, output in_ready);
endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srstn,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, count_q;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/result_writer.sv
// Buffers quantised rows and drains one per cycle onto the shared SRAM write bus.
// Define RESULT_WRITER_DONE_TRACK_EN to build the per-bank completion bitmap.
module result_writer
    import result_writer_pkg::*;
#(
    parameter int ARRAY_SIZE        = RW_ARRAY_SIZE,
    parameter int OUTPUT_DATA_WIDTH = RW_OUTPUT_DATA_WIDTH,
    parameter int NUM_BANKS         = RW_NUM_BANKS,
    parameter int ADDR_WIDTH        = RW_ADDR_WIDTH,
    parameter int ROWS_PER_SET      = RW_ROWS_PER_SET,
    parameter int FIFO_DEPTH        = RW_FIFO_DEPTH
) (
    input  logic                                    clk,
    input  logic                                    srstn,
    result_writer_if.slave                          in_if,
    input  logic                                    sram_stall,
    input  logic                                    clear_done,
    output logic [NUM_BANKS-1:0]                    sram_wen_n,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata,
    output logic [ADDR_WIDTH-1:0]                   sram_waddr,
    output logic [NUM_BANKS-1:0]                    bank_done,
    output logic [DROP_W-1:0]                       drop_cnt
);
    localparam int BW = bank_w(NUM_BANKS);
    localparam int DW = ARRAY_SIZE*OUTPUT_DATA_WIDTH;
    localparam int EW = BW + ADDR_WIDTH + DW;

    logic                  legal, accept, push, pop, full, empty;
    logic [EW-1:0]         head;
    logic [BW-1:0]         head_bank;
    logic [ADDR_WIDTH-1:0] head_row;
    logic [DW-1:0]         head_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt_unused;

    logic [NUM_BANKS-1:0]  wen_n_q, wen_n_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DROP_W-1:0]     drop_q, drop_d;

    // Bad rows are still handshaken so the producer never stalls on them.
    assign legal  = (32'(in_if.in_bank) < NUM_BANKS) && (32'(in_if.in_row) < ROWS_PER_SET);
    assign accept = in_if.in_valid && !full;
    assign push   = accept && legal;
    assign pop    = !empty && !sram_stall;
    assign in_if.in_ready = !full;
    assign {head_bank, head_row, head_data} = head;

    result_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .srstn   (srstn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_if.in_bank, in_if.in_row, in_if.in_data}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt_unused)
    );

    always_comb begin
        wen_n_d = '1;
        waddr_d = '0;
        wdata_d = '0;
        drop_d  = drop_q;
        if (pop) begin
            for (int b = 0; b < NUM_BANKS; b++)
                if (head_bank == BW'(b)) wen_n_d[b] = 1'b0;
            waddr_d = head_row;
            wdata_d = head_data;
        end
        if (accept && !legal && drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            wen_n_q <= '1;
            waddr_q <= '0;
            wdata_q <= '0;
            drop_q  <= '0;
        end else begin
            wen_n_q <= wen_n_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            drop_q  <= drop_d;
        end
    end

    assign sram_wen_n = wen_n_q;
    assign sram_waddr = waddr_q;
    assign sram_wdata = wdata_q;
    assign drop_cnt   = drop_q;

`ifdef RESULT_WRITER_DONE_TRACK_EN
    logic [NUM_BANKS-1:0][ROWS_PER_SET-1:0] seen_q, seen_d;
    logic [NUM_BANKS-1:0]                   done_q, done_d;

    // done lags the bitmap by one edge; clear beats a same-cycle pop.
    always_comb begin
        seen_d = seen_q;
        done_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            done_d[b] = &seen_q[b];
            for (int r = 0; r < ROWS_PER_SET; r++)
                if (pop && head_bank == BW'(b) && head_row == ADDR_WIDTH'(r))
                    seen_d[b][r] = 1'b1;
        end
        if (clear_done) begin
            seen_d = '0;
            done_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            seen_q <= '0;
            done_q <= '0;
        end else begin
            seen_q <= seen_d;
            done_q <= done_d;
        end
    end

    assign bank_done = done_q;
`else
    logic clear_done_unused;
    assign clear_done_unused = clear_done;
    assign bank_done = '0;
`endif
endmodule

// File: tb/tb_result_writer.sv
// Directed plus randomized bench for result_writer against a queue-based model.
module tb_result_writer;
    import result_writer_pkg::*;

    localparam int NB  = 3;
    localparam int RPS = 8;
    localparam int FD  = 4;
    localparam int DW  = 128;

    logic clk = 1'b0;
    logic srstn, sram_stall, clear_done;
    logic [NB-1:0] sram_wen_n, bank_done;
    logic [DW-1:0] sram_wdata;
    logic [5:0]    sram_waddr;
    logic [7:0]    drop_cnt;

    result_writer_if bus ();

    result_writer dut (
        .clk        (clk),
        .srstn      (srstn),
        .in_if      (bus),
        .sram_stall (sram_stall),
        .clear_done (clear_done),
        .sram_wen_n (sram_wen_n),
        .sram_wdata (sram_wdata),
        .sram_waddr (sram_waddr),
        .bank_done  (bank_done),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;

    rw_entry_t     q[$];
    logic [NB-1:0] m_wen, m_done;
    logic [5:0]    m_addr;
    logic [DW-1:0] m_data;
    logic [7:0]    m_drop;
    bit            seen [NB][RPS];
    bit            last_acc;

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input bit v, input logic [1:0] b, input logic [5:0] r, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_bank  = b;
        bus.in_row   = r;
        bus.in_data  = d;
    endtask

    task automatic check();
        bit er;
        er = (q.size() < FD);
        vec++; assert (sram_wen_n === m_wen) else begin miss++; $error("FAIL wen_n got=%b want=%b", sram_wen_n, m_wen); end
        vec++; assert (sram_waddr === m_addr) else begin miss++; $error("FAIL waddr got=%0d want=%0d", sram_waddr, m_addr); end
        vec++; assert (sram_wdata === m_data) else begin miss++; $error("FAIL wdata got=%h want=%h", sram_wdata, m_data); end
        vec++; assert (bus.in_ready === er) else begin miss++; $error("FAIL in_ready got=%b want=%b", bus.in_ready, er); end
        vec++; assert (drop_cnt === m_drop) else begin miss++; $error("FAIL drop_cnt got=%0d want=%0d", drop_cnt, m_drop); end
        vec++; assert (bank_done === m_done) else begin miss++; $error("FAIL bank_done got=%b want=%b", bank_done, m_done); end
    endtask

    // One clock: evaluate the spec's rules on pre-edge inputs, then compare after the edge.
    task automatic tick();
        rw_entry_t     h;
        bit            rdy, lgl, acc, pp;
        logic [NB-1:0] nd;
        last_acc = 1'b0;
        if (!srstn) begin
            q.delete();
            m_wen = '1; m_addr = '0; m_data = '0; m_drop = '0;
            foreach (seen[b, r]) seen[b][r] = 1'b0;
            nd = '0;
        end else begin
            rdy = (q.size() < FD);
            lgl = (int'(bus.in_bank) < NB) && (int'(bus.in_row) < RPS);
            acc = bus.in_valid && rdy;
            pp  = (q.size() != 0) && !sram_stall;
            for (int b = 0; b < NB; b++) begin
                nd[b] = 1'b1;
                for (int r = 0; r < RPS; r++) if (!seen[b][r]) nd[b] = 1'b0;
            end
            if (pp) begin
                h = q.pop_front();
                m_wen = '1;
                m_wen[h.bank] = 1'b0;
                m_addr = h.row;
                m_data = h.data;
                seen[h.bank][h.row] = 1'b1;
            end else begin
                m_wen = '1; m_addr = '0; m_data = '0;
            end
            if (clear_done) begin
                foreach (seen[b, r]) seen[b][r] = 1'b0;
                nd = '0;
            end
            if (acc && lgl) begin
                h.bank = bus.in_bank; h.row = bus.in_row; h.data = bus.in_data;
                q.push_back(h);
            end
            if (acc && !lgl && m_drop != 8'd255) m_drop = m_drop + 8'd1;
            last_acc = acc;
        end
`ifdef RESULT_WRITER_DONE_TRACK_EN
        m_done = nd;
`else
        m_done = '0;
`endif
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic wait_accept(input int limit);
        for (int i = 0; i < limit && !last_acc; i++) tick();
        vec++; assert (last_acc) else begin miss++; $error("FAIL accept_timeout got=0 want=1"); end
        drive(0, '0, '0, '0);
    endtask

    task automatic send(input logic [1:0] b, input logic [5:0] r, input logic [DW-1:0] d);
        drive(1, b, r, d);
        last_acc = 1'b0;
        wait_accept(32);
    endtask

    initial begin
        logic [NB-1:0] want_done;
        srstn = 1'b0; sram_stall = 1'b0; clear_done = 1'b0;
        drive(0, '0, '0, '0);

        // reset then idle
        repeat (3) tick();
        srstn = 1'b1;
        tick();
        vec++; assert (sram_wen_n === 3'b111) else begin miss++; $error("FAIL reset_wen got=%b want=111", sram_wen_n); end
        vec++; assert (bus.in_ready === 1'b1) else begin miss++; $error("FAIL reset_ready got=%b want=1", bus.in_ready); end

        // single write: visible after the second edge, for one cycle
        send(2'd1, 6'd5, 128'hAB);
        tick();
        vec++; assert (sram_wen_n === 3'b101 && sram_waddr === 6'd5) else begin miss++; $error("FAIL single_write got=%b/%0d want=101/5", sram_wen_n, sram_waddr); end
        tick();
        vec++; assert (sram_wen_n === 3'b111) else begin miss++; $error("FAIL single_once got=%b want=111", sram_wen_n); end

        // fill under stall, fifth row waits for the first pop
        sram_stall = 1'b1;
        for (int i = 0; i < 4; i++) send(2'd0, 6'(i), rnd_data());
        vec++; assert (bus.in_ready === 1'b0) else begin miss++; $error("FAIL full_ready got=%b want=0", bus.in_ready); end
        drive(1, 2'd0, 6'd4, rnd_data());
        last_acc = 1'b0;
        tick(); tick();
        sram_stall = 1'b0;
        wait_accept(8);
        repeat (8) tick();

        // illegal rows
        send(2'd3, 6'd0, rnd_data());
        send(2'd0, 6'd8, rnd_data());
        send(2'd0, 6'd63, rnd_data());
        repeat (3) tick();
        vec++; assert (drop_cnt === 8'd3) else begin miss++; $error("FAIL drop3 got=%0d want=3", drop_cnt); end
        drive(1, 2'd3, 6'd7, rnd_data());
        repeat (260) tick();
        drive(0, '0, '0, '0);
        tick();
        vec++; assert (drop_cnt === 8'd255) else begin miss++; $error("FAIL drop_sat got=%0d want=255", drop_cnt); end

        // completion tracking
`ifdef RESULT_WRITER_DONE_TRACK_EN
        want_done = 3'b100;
`else
        want_done = 3'b000;
`endif
        clear_done = 1'b1; tick(); clear_done = 1'b0;
        for (int r = 0; r < 8; r++) send(2'd2, 6'(r), rnd_data());
        tick(); tick();
        vec++; assert (bank_done === want_done) else begin miss++; $error("FAIL done_set got=%b want=%b", bank_done, want_done); end
        clear_done = 1'b1; tick(); clear_done = 1'b0;
        vec++; assert (bank_done === 3'b000) else begin miss++; $error("FAIL done_clear got=%b want=000", bank_done); end
        for (int r = 0; r < 7; r++) send(2'd2, 6'(r), rnd_data());
        repeat (3) tick();
        vec++; assert (bank_done === 3'b000) else begin miss++; $error("FAIL done_partial got=%b want=000", bank_done); end

        // reset while rows are buffered
        sram_stall = 1'b1;
        for (int i = 0; i < 3; i++) send(2'd1, 6'(i), rnd_data());
        srstn = 1'b0; tick(); tick();
        srstn = 1'b1; sram_stall = 1'b0;
        repeat (4) tick();
        vec++; assert (sram_wen_n === 3'b111 && drop_cnt === 8'd0) else begin miss++; $error("FAIL midreset got=%b/%0d want=111/0", sram_wen_n, drop_cnt); end

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 8)), rnd_data());
            sram_stall = ($urandom_range(0, 3) == 0);
            clear_done = ($urandom_range(0, 40) == 0);
            srstn      = ($urandom_range(0, 250) != 0);
            tick();
        end
        drive(0, '0, '0, '0);
        sram_stall = 1'b0; clear_done = 1'b0; srstn = 1'b1;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
